word_loader: RTL and testbench

// - Upstream stage of encoder. Takes a valid/ready byte stream of text and fills the input-word SRAM in encoder format:

---
 rtl/word_loader_pkg.sv | 18 +
 rtl/word_loader_if.sv | 29 ++
 rtl/word_loader_char_class.sv | 27 ++
 rtl/word_loader.sv | 139 +++++++++++++
 tb/tb_word_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/word_loader_pkg.sv
// Shared encoder-side types and constants for the word loader: FSM state encoding and separator byte values.
package tensor_core_pkg;

   typedef enum logic [2:0] {
      L_IDLE = 3'd0,
      L_LOAD = 3'd1,
      L_TERM = 3'd2,
      L_EOT  = 3'd3,
      L_DONE = 3'd4
   } loader_state_t;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TAB   = 8'h09;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_NUL   = 8'h00;

endpackage

// File: rtl/word_loader_if.sv
// Control, byte-stream and SRAM-write bundle of the word loader.
// master = controller/stream source side, slave = the loader itself.
interface word_loader_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [ADDR_WIDTH-1:0] word_count;

   modport master (
      output start, in_valid, in_data, in_last,
      input  in_ready, mem_we, mem_addr, mem_din, busy, done, overflow, word_count
   );

   modport slave (
      input  start, in_valid, in_data, in_last,
      output in_ready, mem_we, mem_addr, mem_din, busy, done, overflow, word_count
   );
endinterface

// File: rtl/word_loader_char_class.sv
// Combinational byte classifier: flags separators and produces the byte to store.
// With LOWERCASE_FOLD_EN defined, A-Z are folded to a-z; otherwise bytes pass through unchanged.
module char_class
   import tensor_core_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_is_sep,
   output logic [DATA_WIDTH-1:0] o_char
);

   assign o_is_sep = (i_data == DATA_WIDTH'(CH_SPACE)) ||
                     (i_data == DATA_WIDTH'(CH_TAB))   ||
                     (i_data == DATA_WIDTH'(CH_LF))    ||
                     (i_data == DATA_WIDTH'(CH_CR))    ||
                     (i_data == DATA_WIDTH'(CH_NUL));

`ifdef LOWERCASE_FOLD_EN
   logic w_is_upper;
   assign w_is_upper = (i_data >= DATA_WIDTH'(8'h41)) && (i_data <= DATA_WIDTH'(8'h5A));
   assign o_char     = w_is_upper ? (i_data + DATA_WIDTH'(8'h20)) : i_data;
`else
   assign o_char = i_data;
`endif

endmodule

// File: rtl/word_loader.sv
// Fills the input-word SRAM from a byte stream: words NUL-terminated, one extra NUL at end of text.
// Separator runs collapse; chars past the reserved tail are dropped and flagged. Optional: LOWERCASE_FOLD_EN.
module word_loader
   import tensor_core_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   word_loader_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   // Two slots are kept back so the final terminator and end-of-text NUL always fit.
   localparam logic [ADDR_WIDTH-1:0] LAST_CHAR_ADDR = ADDR_WIDTH'(DEPTH - 3);

   loader_state_t         r_state;
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic                  r_word_open;
   logic                  r_in_ready;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_din;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_overflow;
   logic [ADDR_WIDTH-1:0] r_word_count;

   logic                  w_is_sep;
   logic [DATA_WIDTH-1:0] w_char;
   logic                  w_accept;
   logic                  w_write_char;
   logic                  w_write_term;
   logic                  w_open_after;

   char_class #(.DATA_WIDTH(DATA_WIDTH)) u_char_class (
      .i_data   (bus.in_data),
      .o_is_sep (w_is_sep),
      .o_char   (w_char)
   );

   assign w_accept     = bus.in_valid & r_in_ready;
   assign w_write_char = !w_is_sep && (r_wptr <= LAST_CHAR_ADDR);
   assign w_write_term = w_is_sep && r_word_open;
   // A dropped char leaves word_open untouched, so only stored chars can open a word.
   assign w_open_after = w_write_char ? 1'b1 : (w_write_term ? 1'b0 : r_word_open);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= L_IDLE;
         r_wptr       <= '0;
         r_word_open  <= 1'b0;
         r_in_ready   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_din    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_overflow   <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            L_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_state      <= L_LOAD;
                  r_in_ready   <= 1'b1;
                  r_busy       <= 1'b1;
                  r_wptr       <= '0;
                  r_word_open  <= 1'b0;
                  r_overflow   <= 1'b0;
                  r_word_count <= '0;
               end
            end
            L_LOAD: begin
               if (w_accept) begin
                  if (w_write_char) begin
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_wptr;
                     r_mem_din   <= w_char;
                     r_wptr      <= r_wptr + ADDR_WIDTH'(1);
                     r_word_open <= 1'b1;
                  end else if (!w_is_sep) begin
                     r_overflow <= 1'b1;
                  end else if (r_word_open) begin
                     r_mem_we     <= 1'b1;
                     r_mem_addr   <= r_wptr;
                     r_mem_din    <= '0;
                     r_wptr       <= r_wptr + ADDR_WIDTH'(1);
                     r_word_open  <= 1'b0;
                     r_word_count <= r_word_count + ADDR_WIDTH'(1);
                  end
                  if (bus.in_last) begin
                     r_in_ready <= 1'b0;
                     r_state    <= w_open_after ? L_TERM : L_EOT;
                  end
               end
            end
            L_TERM: begin
               r_mem_we     <= 1'b1;
               r_mem_addr   <= r_wptr;
               r_mem_din    <= '0;
               r_wptr       <= r_wptr + ADDR_WIDTH'(1);
               r_word_open  <= 1'b0;
               r_word_count <= r_word_count + ADDR_WIDTH'(1);
               r_state      <= L_EOT;
            end
            L_EOT: begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= r_wptr;
               r_mem_din  <= '0;
               r_state    <= L_DONE;
            end
            L_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= L_IDLE;
            end
            default: begin
               r_state    <= L_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_din    = r_mem_din;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.overflow   = r_overflow;
   assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_word_loader.sv
// Directed bench for word_loader: a queue-based image model plus a per-cycle write/done monitor.
module tb_word_loader;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   word_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   word_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   done_seen = 0;
   int   last_we_cyc = -10;
   bit   mon_en   = 1'b0;
   bit   prev_done = 1'b0;

   bq_t  exp_img;
   int   exp_pos;
   int   exp_wc;
   bit   exp_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef LOWERCASE_FOLD_EN
      return (b >= 8'h41 && b <= 8'h5A) ? (b + 8'h20) : b;
`else
      return b;
`endif
   endfunction

   // Image = words in order, each NUL-terminated, chars stop once only two slots remain, then one NUL.
   task automatic build_model(input bq_t s);
      bit open;
      bit sep;
      open = 1'b0;
      exp_img.delete();
      exp_wc  = 0;
      exp_ovf = 1'b0;
      exp_pos = 0;
      foreach (s[i]) begin
         sep = (s[i] == 8'h20) || (s[i] == 8'h09) || (s[i] == 8'h0A) ||
               (s[i] == 8'h0D) || (s[i] == 8'h00);
         if (!sep) begin
            if (exp_img.size() <= DEPTH - 3) begin
               exp_img.push_back(fold(s[i]));
               open = 1'b1;
            end else begin
               exp_ovf = 1'b1;
            end
         end else if (open) begin
            exp_img.push_back(8'h00);
            exp_wc++;
            open = 1'b0;
         end
      end
      if (open) begin
         exp_img.push_back(8'h00);
         exp_wc++;
      end
      exp_img.push_back(8'h00);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: every write must be the next image byte at the next address; done closes the image.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && mon_en) begin
            if (bus.mem_we) begin
               if (exp_pos >= exp_img.size()) begin
                  check("unexpected_write_addr", 32'(bus.mem_addr), 32'hFFFF);
               end else begin
                  check("write_addr", 32'(bus.mem_addr), 32'(exp_pos));
                  check("write_data", 32'(bus.mem_din), 32'(exp_img[exp_pos]));
                  exp_pos++;
                  last_we_cyc = cyc;
               end
            end
            if (prev_done) check("done_one_cycle", 32'(bus.done), 32'd0);
            if (bus.done) begin
               check("done_all_written", 32'(exp_pos), 32'(exp_img.size()));
               check("done_after_eot", 32'(cyc), 32'(last_we_cyc + 1));
               check("done_word_count", 32'(bus.word_count), 32'(exp_wc));
               check("done_overflow", 32'(bus.overflow), 32'(exp_ovf));
               check("done_busy_low", 32'(bus.busy), 32'd0);
               done_seen++;
            end
            prev_done = bus.done;
         end else begin
            prev_done = 1'b0;
         end
      end
   end

   task automatic do_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send(input bq_t s, input bit with_last, input bit drop_valid);
      int n;
      foreach (s[i]) begin
         bus.in_valid = 1'b1;
         bus.in_data  = s[i];
         bus.in_last  = with_last && (i == s.size() - 1);
         n = 0;
         while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) begin
            check("accept_timeout", 32'd1, 32'd0);
            break;
         end
         @(negedge clk);
      end
      if (drop_valid) bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic wait_done();
      int d0;
      int n;
      d0 = done_seen;
      n  = 0;
      while (done_seen == d0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (done_seen == d0) check("done_timeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic run(input string s);
      build_model(str2q(s));
      mon_en = 1'b1;
      do_start();
      check("busy_after_start", 32'(bus.busy), 32'd1);
      check("ready_in_load", 32'(bus.in_ready), 32'd1);
      send(str2q(s), 1'b1, 1'b1);
      wait_done();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, "_mem_din"}, 32'(bus.mem_din), 32'd0);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
      check({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
   endtask

   initial begin
      logic [7:0] lit_hi[7];
      lit_hi = '{8'h68, 8'h69, 8'h00, 8'h79, 8'h6F, 8'h00, 8'h00};
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Pin the model against hand-written images before trusting it.
      build_model(str2q("hi yo"));
      check("pin_hi_size", 32'(exp_img.size()), 32'd7);
      for (int i = 0; i < 7; i++) check("pin_hi_byte", 32'(exp_img[i]), 32'(lit_hi[i]));
      build_model(str2q("xxxxxxxxxxxxxxxxxxxx"));
      check("pin_ovf_size", 32'(exp_img.size()), 32'd16);
      check("pin_ovf_flag", 32'(exp_ovf), 32'd1);
      check("pin_ovf_wc", 32'(exp_wc), 32'd1);

      run("hi yo");
      check("hi_word_count", 32'(bus.word_count), 32'd2);
      check("hi_overflow", 32'(bus.overflow), 32'd0);

      run("  a   b ");
      check("spaces_word_count", 32'(bus.word_count), 32'd2);
      check("spaces_image_len", 32'(exp_pos), 32'd5);

      run("xxxxxxxxxxxxxxxxxxxx");
      check("trunc_word_count", 32'(bus.word_count), 32'd1);
      check("trunc_overflow", 32'(bus.overflow), 32'd1);
      check("trunc_writes", 32'(exp_pos), 32'd16);

      run(" ");
      check("empty_word_count", 32'(bus.word_count), 32'd0);
      check("empty_writes", 32'(exp_pos), 32'd1);

      run("Hi");
`ifdef LOWERCASE_FOLD_EN
      check("fold_first_byte", 32'(exp_img[0]), 32'h68);
`else
      check("fold_first_byte", 32'(exp_img[0]), 32'h48);
`endif
      check("fold_overflow_cleared", 32'(bus.overflow), 32'd0);

      // Hold in_valid through TERM/EOT/DONE/IDLE; nothing may be consumed.
      build_model(str2q("go"));
      do_start();
      send(str2q("go"), 1'b1, 1'b0);
      bus.in_data = 8'h7A;
      bus.in_last = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("hold_ready_low", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      check("hold_done_count", 32'(done_seen), 32'd6);
      build_model(str2q("z"));
      do_start();
      send(str2q("z"), 1'b1, 1'b1);
      wait_done();
      check("hold_second_wc", 32'(bus.word_count), 32'd1);

      // Reset in the middle of a load, then restart cleanly from address 0.
      build_model(str2q("abc"));
      do_start();
      send(str2q("abc"), 1'b0, 1'b1);
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      check_reset_outputs("midrst_edge");
      rst = 1'b0;
      @(negedge clk);
      run("ab");
      check("restart_word_count", 32'(bus.word_count), 32'd1);
      check("restart_writes", 32'(exp_pos), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
